layer_actv_xfer: RTL and testbench

//  Downstream stage of a RAM-based NN layer. When the layer signals completion, it streams NumNeurons raw

---
 rtl/nn_xfer_pkg.sv | 29 ++
 rtl/actv_relu_unit.sv | 53 +++++
 rtl/layer_actv_xfer.sv | 127 ++++++++++++
 tb/tb_layer_actv_xfer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_xfer_pkg.sv
// Shared types and activation function for NN activation-transfer stages.
// LAYER_ACTV_LEAKY_RELU_EN selects leaky ReLU instead of plain ReLU.
package nn_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DN,
        XFER,
        DRAIN,
        HANDOFF
    } xfer_state_e;

    localparam int unsigned ActvWidth = 32;

    // Callers sign-extend into ActvWidth and truncate the result back to their own width
    function automatic logic signed [ActvWidth-1:0] actv_fn(
        input logic signed [ActvWidth-1:0] x,
        input int unsigned                 shift
    );
`ifdef LAYER_ACTV_LEAKY_RELU_EN
        return x[ActvWidth-1] ? (x >>> shift) : x;
`else
        logic unused_shift;
        unused_shift = ^shift;
        return x[ActvWidth-1] ? '0 : x;
`endif
    endfunction

endpackage

// File: rtl/actv_relu_unit.sv
// One registered stage: applies the activation to a read word, emits the
// destination write and tracks the running argmax/max of activated values.
module actv_relu_unit
    import nn_xfer_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned LeakShift = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 vld_i,
    input  logic [AddrWidth-1:0] idx_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] data_o,
    output logic [AddrWidth-1:0] argmax_o,
    output logic [DataWidth-1:0] max_o
);

    logic signed [DataWidth-1:0] actv;
    logic                        upd;

    assign actv = DataWidth'(actv_fn(ActvWidth'($signed(data_i)), LeakShift));
    // Strict greater-than keeps the lowest index on ties; index 0 seeds the search
    assign upd  = vld_i && ((idx_i == '0) || (actv > $signed(max_o)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_o     <= 1'b0;
            addr_o   <= '0;
            data_o   <= '0;
            argmax_o <= '0;
            max_o    <= '0;
        end else begin
            we_o <= vld_i;
            if (vld_i) begin
                addr_o <= idx_i;
                data_o <= actv;
            end
            if (clear_i) begin
                argmax_o <= '0;
                max_o    <= '0;
            end else if (upd) begin
                argmax_o <= idx_i;
                max_o    <= actv;
            end
        end
    end

endmodule

// File: rtl/layer_actv_xfer.sv
// Streams a finished layer's raw sums through ReLU into the next layer's input RAM.
// Define LAYER_ACTV_LEAKY_RELU_EN for leaky ReLU (negative inputs shifted by LeakShift).
module layer_actv_xfer
    import nn_xfer_pkg::*;
#(
    parameter int unsigned NumNeurons = 15,
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned FpWidth    = 4,
    parameter int unsigned AddrWidth  = $clog2(NumNeurons),
    parameter int unsigned LeakShift  = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_i,
    output logic                 ack_o,
    output logic                 ready_o,
    output logic                 req_o,
    input  logic                 ack_i,
    input  logic                 ready_i,
    output logic [AddrWidth-1:0] src_addr_o,
    input  logic [DataWidth-1:0] src_data_i,
    output logic [AddrWidth-1:0] dst_addr_o,
    output logic                 dst_we_o,
    output logic [DataWidth-1:0] dst_data_o,
    output logic [AddrWidth-1:0] argmax_o,
    output logic [DataWidth-1:0] max_o
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumNeurons - 1);

    if (FpWidth > DataWidth) begin : g_fp_chk
        $error("FpWidth must not exceed DataWidth");
    end

    xfer_state_e          state_q, state_d;
    logic                 ack_d, ready_d, req_d, drain_q, drain_d;
    logic [AddrWidth-1:0] addr_d;
    logic                 rd_vld_q;
    logic [AddrWidth-1:0] rd_idx_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ack_o      <= 1'b0;
            ready_o    <= 1'b1;
            req_o      <= 1'b0;
            src_addr_o <= '0;
            drain_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            ack_o      <= ack_d;
            ready_o    <= ready_d;
            req_o      <= req_d;
            src_addr_o <= addr_d;
            drain_q    <= drain_d;
            rd_vld_q   <= (state_q == XFER);
            rd_idx_q   <= src_addr_o;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        req_d   = req_o;
        addr_d  = src_addr_o;
        drain_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    ack_d   = 1'b1;
                    state_d = WAIT_DN;
                end
            end
            WAIT_DN: begin
                if (ready_i) begin
                    addr_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                // Counter parks on the last address rather than wrapping
                if (src_addr_o == LastAddr) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = src_addr_o + AddrWidth'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    req_d   = 1'b1;
                    state_d = HANDOFF;
                end else begin
                    drain_d = 1'b1;
                end
            end
            HANDOFF: begin
                if (ack_i) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    actv_relu_unit #(
        .DataWidth(DataWidth),
        .AddrWidth(AddrWidth),
        .LeakShift(LeakShift)
    ) u_actv (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (ack_d),
        .vld_i   (rd_vld_q),
        .idx_i   (rd_idx_q),
        .data_i  (src_data_i),
        .we_o    (dst_we_o),
        .addr_o  (dst_addr_o),
        .data_o  (dst_data_o),
        .argmax_o(argmax_o),
        .max_o   (max_o)
    );

endmodule

// File: tb/tb_layer_actv_xfer.sv
// Self-checking bench for layer_actv_xfer with NumNeurons=4, LeakShift=2.
module tb_layer_actv_xfer;

    localparam int N  = 4;
    localparam int LS = 2;

    typedef logic [N-1:0][7:0] vec_t;
    typedef struct {
        vec_t       src;
        vec_t       dst;
        logic [1:0] am;
        logic [7:0] mx;
        int         rdy_lag;
        int         ack_lag;
    } vec_rec_t;

    logic       clk = 1'b0;
    logic       reset_i, req_i, ack_i, ready_i;
    logic       ack_o, ready_o, req_o, dst_we_o;
    logic [1:0] src_addr_o, dst_addr_o, argmax_o;
    logic [7:0] src_data_i, dst_data_o, max_o;

    vec_t       src_mem;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         wr_n;
    logic [1:0] wr_addr [16];
    logic [7:0] wr_data [16];
    int         wr_cyc  [16];

    layer_actv_xfer #(
        .NumNeurons(N), .DataWidth(8), .FpWidth(4), .LeakShift(LS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .ack_o(ack_o),
        .ready_o(ready_o), .req_o(req_o), .ack_i(ack_i), .ready_i(ready_i),
        .src_addr_o(src_addr_o), .src_data_i(src_data_i),
        .dst_addr_o(dst_addr_o), .dst_we_o(dst_we_o), .dst_data_o(dst_data_o),
        .argmax_o(argmax_o), .max_o(max_o)
    );

    always #5 clk = ~clk;

    // Source RAM with one cycle of read latency
    always @(posedge clk) src_data_i <= src_mem[src_addr_o];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (dst_we_o) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = dst_addr_o;
                wr_data[wr_n] = dst_data_o;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] a0, a1, a2, a3);
        vec_t v;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        return v;
    endfunction

    // Reference activation: floor division by 2^LS for leaky negatives, else clamp to 0
    function automatic logic [7:0] ref_f(input logic [7:0] x);
        int xi;
        xi = int'($signed(x));
        if (xi >= 0) return x;
`ifdef LAYER_ACTV_LEAKY_RELU_EN
        return 8'((xi - ((1 << LS) - 1)) / (1 << LS));
`else
        return 8'h00;
`endif
    endfunction

    task automatic ref_model(input vec_t src, output vec_t dst, output logic [1:0] am,
                             output logic [7:0] mx);
        int best;
        for (int i = 0; i < N; i++) dst[i] = ref_f(src[i]);
        best = 0;
        for (int i = 1; i < N; i++)
            if ($signed(dst[i]) > $signed(dst[best])) best = i;
        am = 2'(best);
        mx = dst[best];
    endtask

    task automatic run_xfer(input string nm, input vec_t src, input vec_t exp_dst,
                            input logic [1:0] exp_am, input logic [7:0] exp_mx,
                            input int rdy_lag, input int ack_lag);
        int ack_cyc, rdy_cyc, req_cyc, extra_ack;
        bit got;
        src_mem = src;
        wr_n    = 0;
        ready_i = (rdy_lag == 0);
        req_i   = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ack_o) got = 1'b1;
        end
        check({nm, " ack_seen"}, 32'(got), 1);
        req_i = 1'b0;
        if (!got) return;
        ack_cyc = cyc;
        check({nm, " clear_on_ack"}, {22'd0, argmax_o, max_o}, 0);
        rdy_cyc = ack_cyc;
        if (rdy_lag > 0) begin
            for (int i = 0; i < rdy_lag; i++) begin
                step();
                check({nm, " wait_quiet"}, {28'd0, dst_we_o, req_o, ready_o, ack_o}, 0);
            end
            ready_i = 1'b1;
            rdy_cyc = cyc;
        end
        got       = 1'b0;
        extra_ack = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (ack_o) extra_ack++;
            if (req_o) got = 1'b1;
        end
        check({nm, " ack_pulse"}, 32'(extra_ack), 0);
        check({nm, " req_seen"}, 32'(got), 1);
        if (!got) return;
        req_cyc = cyc;
        check({nm, " req_latency"}, 32'(req_cyc - rdy_cyc), 32'(N + 3));
        check({nm, " wr_count"}, 32'(wr_n), 32'(N));
        for (int i = 0; i < N && i < wr_n; i++) begin
            check($sformatf("%s wr%0d_addr", nm, i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("%s wr%0d_data", nm, i), 32'(wr_data[i]), 32'(exp_dst[i]));
            check($sformatf("%s wr%0d_cyc", nm, i), 32'(wr_cyc[i] - rdy_cyc), 32'(3 + i));
        end
        check({nm, " argmax"}, 32'(argmax_o), 32'(exp_am));
        check({nm, " max"}, 32'(max_o), 32'(exp_mx));
        check({nm, " dst_hold"}, {22'd0, dst_we_o, dst_addr_o, dst_data_o},
              {22'd0, 1'b0, 2'(N - 1), exp_dst[N-1]});
        for (int i = 0; i < ack_lag; i++) begin
            req_i = 1'b1;
            step();
            check({nm, " handoff_hold"}, {20'd0, req_o, ack_o, argmax_o, max_o},
                  {20'd0, 1'b1, 1'b0, exp_am, exp_mx});
        end
        req_i = 1'b0;
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check({nm, " req_drop"}, {30'd0, req_o, ready_o}, 32'b01);
    endtask

    initial begin
        vec_rec_t   tbl [7];
        vec_t       rs, rd;
        logic [1:0] ram;
        logic [7:0] rmx;
        bit         got;

        reset_i = 1'b1; req_i = 1'b0; ack_i = 1'b0; ready_i = 1'b0;
        src_mem = '0;
        wr_n    = 0;

`ifdef LAYER_ACTV_LEAKY_RELU_EN
        tbl[0] = '{mk(8'h10, 8'hF0, 8'h30, 8'h30), mk(8'h10, 8'hFC, 8'h30, 8'h30), 2'd2, 8'h30, 0, 0};
        tbl[1] = '{mk(8'h10, 8'hF0, 8'h30, 8'h30), mk(8'h10, 8'hFC, 8'h30, 8'h30), 2'd2, 8'h30, 10, 0};
        tbl[2] = '{mk(8'h05, 8'h7F, 8'h81, 8'h7F), mk(8'h05, 8'h7F, 8'hE0, 8'h7F), 2'd1, 8'h7F, 0, 5};
        tbl[3] = '{mk(8'h80, 8'hFF, 8'h90, 8'hC0), mk(8'hE0, 8'hFF, 8'hE4, 8'hF0), 2'd1, 8'hFF, 0, 0};
`else
        tbl[0] = '{mk(8'h10, 8'hF0, 8'h30, 8'h30), mk(8'h10, 8'h00, 8'h30, 8'h30), 2'd2, 8'h30, 0, 0};
        tbl[1] = '{mk(8'h10, 8'hF0, 8'h30, 8'h30), mk(8'h10, 8'h00, 8'h30, 8'h30), 2'd2, 8'h30, 10, 0};
        tbl[2] = '{mk(8'h05, 8'h7F, 8'h81, 8'h7F), mk(8'h05, 8'h7F, 8'h00, 8'h7F), 2'd1, 8'h7F, 0, 5};
        tbl[3] = '{mk(8'h80, 8'hFF, 8'h90, 8'hC0), mk(8'h00, 8'h00, 8'h00, 8'h00), 2'd0, 8'h00, 0, 0};
`endif
        tbl[4] = '{mk(8'h20, 8'h20, 8'h20, 8'h20), mk(8'h20, 8'h20, 8'h20, 8'h20), 2'd0, 8'h20, 0, 1};
        tbl[5] = '{mk(8'h00, 8'h01, 8'h02, 8'h03), mk(8'h00, 8'h01, 8'h02, 8'h03), 2'd3, 8'h03, 2, 0};
        tbl[6] = '{mk(8'h7F, 8'h10, 8'h7F, 8'h00), mk(8'h7F, 8'h10, 8'h7F, 8'h00), 2'd0, 8'h7F, 0, 0};

        repeat (3) step();
        check("reset_outputs",
              {7'd0, ack_o, ready_o, req_o, dst_we_o, src_addr_o, dst_addr_o, dst_data_o, argmax_o, max_o},
              {7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 2'd0, 8'd0});
        reset_i = 1'b0;
        step();
        check("post_reset_idle", {30'd0, ready_o, ack_o}, 32'b10);

        for (int i = 0; i < 7; i++)
            run_xfer($sformatf("vec%0d", i), tbl[i].src, tbl[i].dst, tbl[i].am, tbl[i].mx,
                     tbl[i].rdy_lag, tbl[i].ack_lag);

        // Reset in the middle of a transfer, after two writes have landed
        src_mem = mk(8'h11, 8'h22, 8'h33, 8'h44);
        wr_n    = 0;
        ready_i = 1'b1;
        req_i   = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ack_o) got = 1'b1;
        end
        req_i = 1'b0;
        check("rst_mid ack_seen", 32'(got), 1);
        for (int i = 0; i < 20 && wr_n < 2; i++) step();
        check("rst_mid two_writes", 32'(wr_n), 2);
        reset_i = 1'b1;
        step();
        check("rst_mid abandon", {29'd0, dst_we_o, req_o, ready_o}, 32'b001);
        reset_i = 1'b0;
        step();
        check("rst_mid no_more_writes", 32'(wr_n), 2);
        run_xfer("after_rst", mk(8'h01, 8'h09, 8'hF9, 8'h09), mk(8'h01, 8'h09, ref_f(8'hF9), 8'h09),
                 2'd1, 8'h09, 0, 0);

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < N; i++) rs[i] = 8'($urandom);
            ref_model(rs, rd, ram, rmx);
            run_xfer($sformatf("rnd%0d", t), rs, rd, ram, rmx,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
